video_mnist_seg_argmax: RTL and testbench
=========================================

# video_mnist_seg_argmax

Per-pixel class decision stage for the MNIST segmentation video path. It receives per-pixel vote counts for 11 classes (digits 0–9, background) alongside the RGB pixel. It produces the winning class number, the winning count, a luminance binarization bit and a detection flag. Its outputs feed the segmentation colour stage directly: tnumber, tcount, tbinary and tdetection are that stage's per-pixel inputs.

## Interface
Parameters:
- TUSER_WIDTH, 1, tuser width
- TDATA_WIDTH, 24, pixel width; RGB with R=[23:16], G=[15:8], B=[7:0]
- TNUMBER_WIDTH, 4, class number width (must hold 10)
- TCOUNT_WIDTH, 4, per-class vote count width

Ports:
- aclk  in  1  clock; one clock
- aresetn  in  1  reset; asynchronous and active-low
- param_bin_th  in  8  luminance threshold for tbinary
- param_det_th  in  TCOUNT_WIDTH  minimum digit vote count for tdetection
- s_axi4s_tuser  in  TUSER_WIDTH  frame start
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  TDATA_WIDTH  RGB pixel
- s_axi4s_tclass  in  11*TCOUNT_WIDTH  class c count at [c*TCOUNT_WIDTH +: TCOUNT_WIDTH]; c=10 is background
- s_axi4s_tvalid  in  1  input valid
- s_axi4s_tready  out  1  input ready
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser
- m_axi4s_tlast  out  1  delayed tlast
- m_axi4s_tnumber  out  TNUMBER_WIDTH  argmax class, 0–10
- m_axi4s_tcount  out  TCOUNT_WIDTH  count of the argmax class
- m_axi4s_tdata  out  TDATA_WIDTH  delayed pixel, unmodified
- m_axi4s_tbinary  out  1  luminance >= param_bin_th
- m_axi4s_tdetection  out  1  best digit count >= param_det_th
- m_axi4s_tvalid  out  1  output valid
- m_axi4s_tready  in  1  output ready

## Operation
- Argmax over all 11 classes uses a compare-select tree of 11→6→3→2→1. Class 10 passes through the first level unpaired.
  - Each node keeps the lower index unless the higher-index count is strictly greater. Ties therefore resolve to the lowest index.
  - tcount is the winner's count.
- A separate digit-only maximum is taken over classes 0–9. It shares the tree nodes, excluding class 10.
  - tdetection = (digit max >= param_det_th).
  - tdetection is independent of whether background won.
- Luminance is Y = (77·R + 150·G + 29·B) >> 8.
  - The sum is 16 bits unsigned; its maximum is 65280, so there is no overflow.
  - Y is 8 bits.
  - tbinary = (Y >= param_bin_th), unsigned.
- tuser, tlast and tdata pass through unchanged, aligned with the results.
- Parameters are sampled in the final stage on the cycle it advances. Software changes them only in vertical blanking.

## Timing
- Four pipeline stages; latency is 4 advancing cycles.
- One global enable: s_axi4s_tready = m_axi4s_tready || !m_axi4s_tvalid. All stages advance together when it is high.
  - Per-stage valid bits shift with the data, so bubbles propagate as invalid.
  - Throughput is 1 pixel/clock when m_axi4s_tready is held high.
- Output stall: when m_axi4s_tvalid=1 and m_axi4s_tready=0, all m_* outputs hold stable and tready=0.
- Reset: all stage valids and m_axi4s_tvalid go to 0, and all other outputs go to 0. s_axi4s_tready is 1 while in reset.
- Reset mid-stream drops in-flight pixels without a partial output.
- An input with tvalid=0 accepted while tready=1 enters the pipe as a bubble. Its data fields are don't-care, but they are still registered.

## Structure
- Package video_mnist_seg_pkg holds:
  - NUM_CLASSES=11 and BGC_NUMBER=10.
  - The luma coefficients 77/150/29.
  - A function that unpacks class counts.
- Sub-module video_mnist_seg_argmax_node: one registered compare-select.
  - Inputs: index/count pair A, index/count pair B, enable.
  - Output: the winning index/count, with ties going to A.
  - It is instantiated per tree level.
- Luminance multiply-add is pipelined inline across stages 0–2. The compare against param_bin_th happens in stage 3.

## Test plan
- Counts: class3=9, others 2, bg=1; param_det_th=5 → after 4 cycles, tnumber=3, tcount=9, tdetection=1.
- Counts all 7, including bg → tnumber=0, tcount=7, because the lowest index wins the tie.
- bg=12, digit max=6, param_det_th=6 → tnumber=10, tcount=12, tdetection=1. Same input with param_det_th=7 → tdetection=0.
- tdata=24'hFF_FF_FF with param_bin_th=255 → tbinary=1 (Y=255). tdata=24'h00_00_01 with param_bin_th=1 → tbinary=0 (Y=0).
- Random m_axi4s_tready with a 64-pixel line:
  - Output order and tuser/tlast positions match the input.
  - Outputs are stable during stalls.
  - No pixel is lost or duplicated.
- Assert aresetn mid-line with 3 pixels in flight → m_axi4s_tvalid=0 immediately. After release, no stale pixel is emitted and the first new pixel appears 4 cycles after acceptance.

Source files
------------

// File: rtl/video_mnist_seg_argmax_pkg.sv
// Shared constants and helpers for the MNIST segmentation per-pixel decision stage.
package video_mnist_seg_pkg;

  localparam int NUM_CLASSES = 11;
  localparam int BGC_NUMBER  = 10;
  localparam int CNT_W_MAX   = 16;
  localparam int FLAT_W      = NUM_CLASSES * CNT_W_MAX;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  // Extracts the w-bit count of class c from a zero-extended flat class vector.
  function automatic logic [CNT_W_MAX-1:0] class_count(input logic [FLAT_W-1:0] flat,
                                                       input int c, input int w);
    logic [CNT_W_MAX-1:0] mask;
    mask = {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
    return CNT_W_MAX'(flat >> (c * w)) & mask;
  endfunction

endpackage

// File: rtl/video_mnist_seg_argmax_node.sv
// One registered compare-select node of the argmax tree; ties keep input A.
module video_mnist_seg_argmax_node #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [IDX_W-1:0] a_idx_i,
  input  logic [CNT_W-1:0] a_cnt_i,
  input  logic [IDX_W-1:0] b_idx_i,
  input  logic [CNT_W-1:0] b_cnt_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             b_wins;

  assign b_wins = b_cnt_i > a_cnt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      idx_q <= b_wins ? b_idx_i : a_idx_i;
      cnt_q <= b_wins ? b_cnt_i : a_cnt_i;
    end
  end

  assign idx_o = idx_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/video_mnist_seg_argmax.sv
// Per-pixel argmax over 11 class votes, digit detection and luma binarization, 4-stage pipe.
module video_mnist_seg_argmax
  import video_mnist_seg_pkg::*;
#(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 24,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 4
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [7:0]                          param_bin_th,
  input  logic [TCOUNT_WIDTH-1:0]             param_det_th,
  input  logic [TUSER_WIDTH-1:0]              s_axi4s_tuser,
  input  logic                                s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]              s_axi4s_tdata,
  input  logic [NUM_CLASSES*TCOUNT_WIDTH-1:0] s_axi4s_tclass,
  input  logic                                s_axi4s_tvalid,
  output logic                                s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]              m_axi4s_tuser,
  output logic                                m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0]            m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]             m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]              m_axi4s_tdata,
  output logic                                m_axi4s_tbinary,
  output logic                                m_axi4s_tdetection,
  output logic                                m_axi4s_tvalid,
  input  logic                                m_axi4s_tready
);

  localparam int NW = TNUMBER_WIDTH;
  localparam int CW = TCOUNT_WIDTH;

  logic en;
  logic [CW-1:0] cnt [NUM_CLASSES];

  logic vld_p0, vld_p1, vld_p2;
  logic [TUSER_WIDTH-1:0] user_p0, user_p1, user_p2;
  logic last_p0, last_p1, last_p2;
  logic [TDATA_WIDTH-1:0] data_p0, data_p1, data_p2;
  logic [15:0] lr_p0, lg_p0, lb_p0, ls_p1, lb_p1, lsum_p2;

  logic [NW-1:0] n_idx [5];
  logic [CW-1:0] n_cnt [5];
  logic [CW-1:0] bg_cnt_p0;
  logic [NW-1:0] m_idx [3];
  logic [CW-1:0] m_cnt [3];
  logic [CW-1:0] dn4_cnt_p1, dn4_cnt_p2;
  logic [NW-1:0] k0_idx, k1_idx_p2;
  logic [CW-1:0] k0_cnt, k1_cnt_p2;

  logic m_tvalid_q, m_tlast_q, m_tbinary_q, m_tdetection_q;
  logic [TUSER_WIDTH-1:0] m_tuser_q;
  logic [TDATA_WIDTH-1:0] m_tdata_q;

  assign en             = m_axi4s_tready || !m_tvalid_q;
  assign s_axi4s_tready = en;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_unpack
    assign cnt[c] = CW'(class_count(FLAT_W'(s_axi4s_tclass), c, CW));
  end

  // Stage 0: pair up digits 0-9, background rides alongside; luma products
  for (genvar i = 0; i < 5; i++) begin : g_lvl1
    video_mnist_seg_argmax_node #(.IDX_W(NW), .CNT_W(CW)) u_node (
      .clk(aclk), .rst_n(aresetn), .en_i(en),
      .a_idx_i(NW'(2*i)),   .a_cnt_i(cnt[2*i]),
      .b_idx_i(NW'(2*i+1)), .b_cnt_i(cnt[2*i+1]),
      .idx_o(n_idx[i]), .cnt_o(n_cnt[i])
    );
  end

  // Stage 1: 6 -> 3; the (8/9) winner is also kept aside as a digit-only candidate
  for (genvar j = 0; j < 2; j++) begin : g_lvl2
    video_mnist_seg_argmax_node #(.IDX_W(NW), .CNT_W(CW)) u_node (
      .clk(aclk), .rst_n(aresetn), .en_i(en),
      .a_idx_i(n_idx[2*j]),   .a_cnt_i(n_cnt[2*j]),
      .b_idx_i(n_idx[2*j+1]), .b_cnt_i(n_cnt[2*j+1]),
      .idx_o(m_idx[j]), .cnt_o(m_cnt[j])
    );
  end

  video_mnist_seg_argmax_node #(.IDX_W(NW), .CNT_W(CW)) u_lvl2_bg (
    .clk(aclk), .rst_n(aresetn), .en_i(en),
    .a_idx_i(n_idx[4]),        .a_cnt_i(n_cnt[4]),
    .b_idx_i(NW'(BGC_NUMBER)), .b_cnt_i(bg_cnt_p0),
    .idx_o(m_idx[2]), .cnt_o(m_cnt[2])
  );

  // Stage 2: 3 -> 2
  video_mnist_seg_argmax_node #(.IDX_W(NW), .CNT_W(CW)) u_lvl3 (
    .clk(aclk), .rst_n(aresetn), .en_i(en),
    .a_idx_i(m_idx[0]), .a_cnt_i(m_cnt[0]),
    .b_idx_i(m_idx[1]), .b_cnt_i(m_cnt[1]),
    .idx_o(k0_idx), .cnt_o(k0_cnt)
  );

  // Stage 3: 2 -> 1 lands directly in the output registers
  video_mnist_seg_argmax_node #(.IDX_W(NW), .CNT_W(CW)) u_lvl4 (
    .clk(aclk), .rst_n(aresetn), .en_i(en),
    .a_idx_i(k0_idx),    .a_cnt_i(k0_cnt),
    .b_idx_i(k1_idx_p2), .b_cnt_i(k1_cnt_p2),
    .idx_o(m_axi4s_tnumber), .cnt_o(m_axi4s_tcount)
  );

  always_ff @(posedge aclk) begin
    if (en) begin
      user_p0    <= s_axi4s_tuser;
      last_p0    <= s_axi4s_tlast;
      data_p0    <= s_axi4s_tdata;
      lr_p0      <= {8'h00, s_axi4s_tdata[23:16]} * {8'h00, LUMA_R};
      lg_p0      <= {8'h00, s_axi4s_tdata[15:8]}  * {8'h00, LUMA_G};
      lb_p0      <= {8'h00, s_axi4s_tdata[7:0]}   * {8'h00, LUMA_B};
      bg_cnt_p0  <= cnt[BGC_NUMBER];
      user_p1    <= user_p0;
      last_p1    <= last_p0;
      data_p1    <= data_p0;
      ls_p1      <= lr_p0 + lg_p0;
      lb_p1      <= lb_p0;
      dn4_cnt_p1 <= n_cnt[4];
      user_p2    <= user_p1;
      last_p2    <= last_p1;
      data_p2    <= data_p1;
      lsum_p2    <= ls_p1 + lb_p1;
      k1_idx_p2  <= m_idx[2];
      k1_cnt_p2  <= m_cnt[2];
      dn4_cnt_p2 <= dn4_cnt_p1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
      vld_p2         <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tuser_q      <= '0;
      m_tlast_q      <= 1'b0;
      m_tdata_q      <= '0;
      m_tbinary_q    <= 1'b0;
      m_tdetection_q <= 1'b0;
    end else if (en) begin
      vld_p0         <= s_axi4s_tvalid;
      vld_p1         <= vld_p0;
      vld_p2         <= vld_p1;
      m_tvalid_q     <= vld_p2;
      m_tuser_q      <= user_p2;
      m_tlast_q      <= last_p2;
      m_tdata_q      <= data_p2;
      // (sum >> 8) >= th is the same test as sum >= th * 256
      m_tbinary_q    <= lsum_p2 >= {param_bin_th, 8'h00};
      m_tdetection_q <= (k0_cnt >= param_det_th) || (dn4_cnt_p2 >= param_det_th);
    end
  end

  assign m_axi4s_tvalid     = m_tvalid_q;
  assign m_axi4s_tuser      = m_tuser_q;
  assign m_axi4s_tlast      = m_tlast_q;
  assign m_axi4s_tdata      = m_tdata_q;
  assign m_axi4s_tbinary    = m_tbinary_q;
  assign m_axi4s_tdetection = m_tdetection_q;

endmodule

// File: tb/tb_video_mnist_seg_argmax.sv
// Directed bench for video_mnist_seg_argmax: argmax, detection, luma threshold, stalls, reset.
module tb_video_mnist_seg_argmax;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  bin_th = 8'd0;
  logic [3:0]  det_th = 4'd0;
  logic [0:0]  s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [23:0] s_tdata = 24'h0;
  logic [43:0] s_tclass = 44'h0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic [3:0]  m_tnumber;
  logic [3:0]  m_tcount;
  logic [23:0] m_tdata;
  logic        m_tbinary;
  logic        m_tdetection;
  logic        m_tvalid;
  logic        m_tready = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  video_mnist_seg_argmax dut (
    .aclk(aclk), .aresetn(aresetn),
    .param_bin_th(bin_th), .param_det_th(det_th),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
    .s_axi4s_tclass(s_tclass), .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
    .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tbinary(m_tbinary),
    .m_axi4s_tdetection(m_tdetection), .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] px_data(input int k);
    return {8'(k * 4), 8'(255 - k * 3), 8'(k * 7 + 13)};
  endfunction

  function automatic logic [43:0] px_class(input int k);
    return 44'(15) << ((k % 11) * 4);
  endfunction

  function automatic logic lum_bin(input logic [23:0] d, input logic [7:0] th);
    int y;
    y = (77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0])) / 256;
    return y >= int'(th);
  endfunction

  function automatic logic [63:0] obs_pack();
    return 64'({m_tuser, m_tlast, m_tdata, m_tnumber, m_tcount, m_tbinary, m_tdetection});
  endfunction

  function automatic logic [63:0] exp_pack(input int k);
    logic [23:0] d;
    d = px_data(k);
    return 64'({(k == 0), (k == 63), d, 4'(k % 11), 4'd15, lum_bin(d, 8'd100), ((k % 11) != 10)});
  endfunction

  task automatic run_px(input logic [43:0] tc, input logic [23:0] td);
    @(negedge aclk);
    s_tclass = tc; s_tdata = td; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    chk("latency_not_yet", 64'(m_tvalid), 64'(0));
    @(negedge aclk);
    chk("latency_valid", 64'(m_tvalid), 64'(1));
  endtask

  initial begin
    logic [43:0] tc;
    logic [23:0] lt_d  [10] = '{24'hFFFFFF, 24'h000001, 24'h808080, 24'h808080, 24'h00FF00,
                                24'h00FF00, 24'hFF0000, 24'hFF0000, 24'h0000FF, 24'h0000FF};
    logic [7:0]  lt_th [10] = '{8'd255, 8'd1, 8'd128, 8'd129, 8'd149,
                                8'd150, 8'd76, 8'd77, 8'd28, 8'd29};
    logic        lt_b  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int ni, no;
    logic stall;
    logic [63:0] saved;

    // reset state
    repeat (2) @(negedge aclk);
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tready", 64'(s_tready), 64'(1));
    chk("rst_outputs", obs_pack(), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;

    // class 3 wins clearly
    det_th = 4'd5; bin_th = 8'd1;
    tc = {11{4'd2}};
    tc[12 +: 4] = 4'd9;
    tc[40 +: 4] = 4'd1;
    run_px(tc, 24'h000000);
    chk("c3_number", 64'(m_tnumber), 64'(3));
    chk("c3_count", 64'(m_tcount), 64'(9));
    chk("c3_detect", 64'(m_tdetection), 64'(1));
    chk("c3_binary", 64'(m_tbinary), 64'(0));

    // all-equal tie goes to class 0
    bin_th = 8'd255;
    run_px({11{4'd7}}, 24'hFFFFFF);
    chk("tie_number", 64'(m_tnumber), 64'(0));
    chk("tie_count", 64'(m_tcount), 64'(7));
    chk("tie_data", 64'(m_tdata), 64'(24'hFFFFFF));
    chk("tie_binary", 64'(m_tbinary), 64'(1));

    // background wins, digit max 6 on class 5
    tc = {11{4'd3}};
    tc[20 +: 4] = 4'd6;
    tc[40 +: 4] = 4'd12;
    det_th = 4'd6;
    run_px(tc, 24'h000000);
    chk("bg_number", 64'(m_tnumber), 64'(10));
    chk("bg_count", 64'(m_tcount), 64'(12));
    chk("bg_det_th6", 64'(m_tdetection), 64'(1));
    det_th = 4'd7;
    run_px(tc, 24'h000000);
    chk("bg_det_th7", 64'(m_tdetection), 64'(0));

    // digit max on class 9, which shares a node with background
    tc = {11{4'd3}};
    tc[36 +: 4] = 4'd6;
    tc[40 +: 4] = 4'd12;
    det_th = 4'd6;
    run_px(tc, 24'h000000);
    chk("bg9_number", 64'(m_tnumber), 64'(10));
    chk("bg9_det", 64'(m_tdetection), 64'(1));

    // luma threshold boundaries per colour channel
    for (int i = 0; i < 10; i++) begin
      bin_th = lt_th[i];
      run_px(44'h0, lt_d[i]);
      chk($sformatf("luma_%0d", i), 64'(m_tbinary), 64'(lt_b[i]));
    end

    // 64-pixel line with random backpressure and input bubbles
    det_th = 4'd5; bin_th = 8'd100;
    ni = 0; no = 0; stall = 1'b0; saved = '0;
    for (int cyc = 0; cyc < 3000 && no < 64; cyc++) begin
      @(negedge aclk);
      if (stall) chk("stall_hold", {27'd0, m_tvalid, obs_pack()[35:0]}, saved);
      m_tready = 1'($urandom_range(0, 1));
      if (ni < 64 && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1; s_tdata = px_data(ni); s_tclass = px_class(ni);
        s_tuser = 1'(ni == 0); s_tlast = (ni == 63);
      end else begin
        s_tvalid = 1'b0;
      end
      #1;
      if (m_tvalid && m_tready) begin
        chk($sformatf("stream_px%0d", no), obs_pack(), exp_pack(no));
        no++;
      end
      stall = m_tvalid && !m_tready;
      saved = {27'd0, m_tvalid, obs_pack()[35:0]};
      if (s_tvalid && s_tready) ni++;
    end
    chk("stream_out_count", 64'(no), 64'(64));
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (6) @(negedge aclk);
    chk("stream_no_extra", 64'(m_tvalid), 64'(0));

    // reset mid-line: one pixel at the output, three in flight
    for (int k = 1; k <= 4; k++) begin
      @(negedge aclk);
      s_tvalid = 1'b1; s_tdata = px_data(k); s_tclass = px_class(k);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    chk("pre_rst_valid", 64'(m_tvalid), 64'(1));
    chk("pre_rst_number", 64'(m_tnumber), 64'(1));
    aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_tvalid), 64'(0));
    chk("mid_rst_number", 64'(m_tnumber), 64'(0));
    chk("mid_rst_tready", 64'(s_tready), 64'(1));
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      chk($sformatf("post_rst_idle%0d", c), 64'(m_tvalid), 64'(0));
    end
    run_px(px_class(5), px_data(5));
    chk("post_rst_number", 64'(m_tnumber), 64'(5));
    chk("post_rst_data", 64'(m_tdata), 64'(px_data(5)));
    @(negedge aclk);
    chk("post_rst_single", 64'(m_tvalid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
